// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop rx synchroniser, 3-sample majority voting,
// configurable data/parity/stop format and a valid/ack output with overrun detection.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] CNT_LO   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(M);
  localparam logic [CW-1:0] CNT_HI   = CW'(M + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP  = (STOP_BITS == 2);
  localparam logic          ODD_PARITY = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                 rx_meta_reg, rx_s_reg;
  state_t               state_reg, state_next;
  logic                 armed_reg, armed_next;
  logic [CW-1:0]        tick_reg, tick_next;
  logic [IW-1:0]        bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 samp_a_reg, samp_a_next;
  logic                 samp_b_reg, samp_b_next;
  logic                 bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 pub_reg, pub_next;
  logic                 maj;
  logic                 end_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg  <= 1'b1;
      rx_s_reg     <= 1'b1;
      state_reg    <= IDLE;
      armed_reg    <= 1'b0;
      tick_reg     <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      samp_a_reg   <= 1'b0;
      samp_b_reg   <= 1'b0;
      bit_reg      <= 1'b0;
      shift_reg    <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      pub_reg      <= 1'b0;
    end else begin
      rx_meta_reg  <= rx;
      rx_s_reg     <= rx_meta_reg;
      state_reg    <= state_next;
      armed_reg    <= armed_next;
      tick_reg     <= tick_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      samp_a_reg   <= samp_a_next;
      samp_b_reg   <= samp_b_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
      pub_reg      <= pub_next;
    end
  end

  // Third vote is the live synchronised sample at count M+1.
  assign maj     = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s_reg) | (samp_b_reg & rx_s_reg);
  assign end_bit = (tick_reg == CNT_END);

  always_comb begin
    state_next    = state_reg;
    armed_next    = armed_reg;
    tick_next     = tick_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    samp_a_next   = samp_a_reg;
    samp_b_next   = samp_b_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    perr_next     = perr_reg;
    ferr_next     = ferr_reg;
    pub_next      = 1'b0;

    if (baud_tick) begin
      if (state_reg != IDLE) begin
        tick_next = end_bit ? '0 : tick_reg + CW'(1);
        if (tick_reg == CNT_LO)  samp_a_next = rx_s_reg;
        if (tick_reg == CNT_MID) samp_b_next = rx_s_reg;
        if (tick_reg == CNT_HI)  bit_next    = maj;
      end

      case (state_reg)
        IDLE: begin
          if (rx_s_reg) begin
            armed_next = 1'b1;
          end else if (armed_reg) begin
            state_next = START;
            tick_next  = '0;
            armed_next = 1'b0;
            perr_next  = 1'b0;
            ferr_next  = 1'b0;
          end
        end
        START: begin
          if (tick_reg == CNT_HI && maj) begin
            state_next = IDLE;
            tick_next  = '0;
          end else if (end_bit) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end
        DATA: begin
          if (end_bit) begin
            shift_next = {bit_reg, shift_reg[DATA_BITS-1:1]};
            if (bit_idx_reg == LAST_IDX) begin
              state_next    = (PARITY_EN != 0) ? PARITY : STOP;
              stop_idx_next = 1'b0;
            end else begin
              bit_idx_next = bit_idx_reg + IW'(1);
            end
          end
        end
        PARITY: begin
          if (end_bit) begin
            perr_next  = ((^shift_reg) ^ bit_reg) != ODD_PARITY;
            state_next = STOP;
          end
        end
        STOP: begin
          if (end_bit) begin
            ferr_next = ferr_reg | ~bit_reg;
            if (stop_idx_reg == LAST_STOP) begin
              pub_next   = 1'b1;
              state_next = IDLE;
            end else begin
              stop_idx_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output handshake runs every clk; a publish in the same cycle as an ack is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (pub_reg) begin
      data_out    <= shift_reg;
      parity_err  <= perr_reg;
      frame_err   <= ferr_reg;
      data_valid  <= 1'b1;
      overrun_err <= data_valid & ~data_ack;
    end else if (data_ack && data_valid) begin
      data_valid  <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign busy = (state_reg != IDLE);

endmodule
